// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith ops plus iterative unsigned MUL and DIVU
// sharing one (WIDTH+1)-bit add/subtract datapath, behind a start/busy/done handshake.
module alu_mc #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [3:0]       i_ctrl,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic [WIDTH-1:0] o_hi,
    output logic             o_zero,
    output logic             o_overflow,
    output logic             o_dbz,
    output logic             o_busy,
    output logic             o_done
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b0101;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_XOR  = 4'b1101;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t r_state, w_state_next;

    logic [CW-1:0]    r_cnt;
    logic             r_mul;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_opd;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_hi;
    logic             r_zero;
    logic             r_ovf;
    logic             r_dbz;

    logic             w_accept;
    logic             w_is_mul;
    logic             w_b_zero;
    logic             w_multi;
    logic             w_last;

    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_sc_result;
    logic [WIDTH-1:0] w_sc_hi;
    logic             w_sc_ovf;
    logic             w_sc_dbz;

    logic [WIDTH:0]   w_x;
    logic [WIDTH:0]   w_y;
    logic [WIDTH:0]   w_alu;
    logic [WIDTH:0]   w_mul_add;
    logic             w_qbit;
    logic [WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0] w_q_next;

    assign w_accept = (r_state == StIdle) && i_start;
    assign w_is_mul = (i_ctrl == OP_MUL);
    assign w_b_zero = (i_b == '0);
    assign w_multi  = w_is_mul || ((i_ctrl == OP_DIVU) && !w_b_zero);
    assign w_last   = (r_cnt == CW'(1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_state_next = w_multi ? StRun : StDone;
                end
            end
            StRun: begin
                if (w_last) begin
                    w_state_next = StDone;
                end
            end
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    assign w_sum  = i_a + i_b;
    assign w_diff = i_a - i_b;

    always_comb begin
        w_sc_result = '0;
        w_sc_hi     = '0;
        w_sc_ovf    = 1'b0;
        w_sc_dbz    = 1'b0;
        case (i_ctrl)
            OP_AND:  w_sc_result = i_a & i_b;
            OP_OR:   w_sc_result = i_a | i_b;
            OP_ADD: begin
                w_sc_result = w_sum;
                w_sc_ovf    = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_sc_result = w_diff;
                w_sc_ovf    = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_diff[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_SLT:  w_sc_result = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            OP_SLTU: w_sc_result = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
            OP_NOR:  w_sc_result = ~(i_a | i_b);
            OP_XOR:  w_sc_result = i_a ^ i_b;
            // Only reached as a single-cycle op when the divisor is zero.
            OP_DIVU: begin
                w_sc_result = '1;
                w_sc_hi     = i_a;
                w_sc_dbz    = 1'b1;
            end
            default: w_sc_result = '0;
        endcase
    end

    // Shared datapath: MUL adds multiplicand to the high accumulator; DIVU subtracts
    // the divisor from the partial remainder shifted left by one dividend bit.
    assign w_x       = r_mul ? {1'b0, r_acc} : {r_acc, r_q[WIDTH-1]};
    assign w_y       = {1'b0, r_opd};
    assign w_alu     = r_mul ? (w_x + w_y) : (w_x - w_y);
    assign w_mul_add = r_q[0] ? w_alu : {1'b0, r_acc};
    assign w_qbit    = ~w_alu[WIDTH];

    always_comb begin
        w_acc_next = '0;
        w_q_next   = '0;
        if (r_mul) begin
            w_acc_next = w_mul_add[WIDTH:1];
            w_q_next   = {w_mul_add[0], r_q[WIDTH-1:1]};
        end else begin
            w_acc_next = w_qbit ? w_alu[WIDTH-1:0] : w_x[WIDTH-1:0];
            w_q_next   = {r_q[WIDTH-2:0], w_qbit};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_mul    <= 1'b0;
            r_acc    <= '0;
            r_q      <= '0;
            r_opd    <= '0;
            r_result <= '0;
            r_hi     <= '0;
            r_zero   <= 1'b1;
            r_ovf    <= 1'b0;
            r_dbz    <= 1'b0;
        end else if (w_accept) begin
            if (w_multi) begin
                r_mul <= w_is_mul;
                r_acc <= '0;
                r_q   <= w_is_mul ? i_b : i_a;
                r_opd <= w_is_mul ? i_a : i_b;
                r_cnt <= CW'(WIDTH);
            end else begin
                r_result <= w_sc_result;
                r_hi     <= w_sc_hi;
                r_zero   <= (w_sc_result == '0);
                r_ovf    <= w_sc_ovf;
                r_dbz    <= w_sc_dbz;
            end
        end else if (r_state == StRun) begin
            r_acc <= w_acc_next;
            r_q   <= w_q_next;
            r_cnt <= r_cnt - 1'b1;
            if (w_last) begin
                r_result <= w_q_next;
                r_hi     <= w_acc_next;
                r_zero   <= (w_q_next == '0);
                r_ovf    <= 1'b0;
                r_dbz    <= 1'b0;
            end
        end
    end

    assign o_result   = r_result;
    assign o_hi       = r_hi;
    assign o_zero     = r_zero;
    assign o_overflow = r_ovf;
    assign o_dbz      = r_dbz;
    assign o_busy     = (r_state != StIdle);
    assign o_done     = (r_state == StDone);

endmodule

// File: tb/tb_alu_mc.sv
// Randomized self-checking bench for alu_mc at WIDTH=32 and WIDTH=4 against an
// arithmetic reference model.
module tb_alu_mc;

    logic        clk;
    logic        rst;

    logic        s32_start;
    logic [3:0]  s32_ctrl;
    logic [31:0] s32_a, s32_b;
    logic [31:0] o32_result, o32_hi;
    logic        o32_zero, o32_ovf, o32_dbz, o32_busy, o32_done;

    logic        s4_start;
    logic [3:0]  s4_ctrl;
    logic [3:0]  s4_a, s4_b;
    logic [3:0]  o4_result, o4_hi;
    logic        o4_zero, o4_ovf, o4_dbz, o4_busy, o4_done;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] g_res, g_hi;

    alu_mc #(.WIDTH(32)) u_dut32 (
        .i_clk(clk), .i_rst(rst), .i_start(s32_start), .i_ctrl(s32_ctrl),
        .i_a(s32_a), .i_b(s32_b), .o_result(o32_result), .o_hi(o32_hi),
        .o_zero(o32_zero), .o_overflow(o32_ovf), .o_dbz(o32_dbz),
        .o_busy(o32_busy), .o_done(o32_done)
    );

    alu_mc #(.WIDTH(4)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_start(s4_start), .i_ctrl(s4_ctrl),
        .i_a(s4_a), .i_b(s4_b), .o_result(o4_result), .o_hi(o4_hi),
        .o_zero(o4_zero), .o_overflow(o4_ovf), .o_dbz(o4_dbz),
        .o_busy(o4_busy), .o_done(o4_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on w-bit values.
    task automatic model(input int w, input logic [3:0] c, input logic [63:0] a_in,
                         input logic [63:0] b_in, output logic [63:0] res,
                         output logic [63:0] hi, output logic ovf, output logic dbz,
                         output int lat);
        logic [63:0] mask, a, b, p;
        longint sa, sb, s, smax, smin;
        mask = (64'd1 << w) - 64'd1;
        a = a_in & mask;
        b = b_in & mask;
        sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
        sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
        smax = (longint'(1) << (w - 1)) - 1;
        smin = -(longint'(1) << (w - 1));
        res = 0; hi = 0; ovf = 0; dbz = 0; lat = 1;
        case (c)
            4'b0000: res = a & b;
            4'b0001: res = a | b;
            4'b0010: begin res = (a + b) & mask; s = sa + sb; ovf = (s > smax) || (s < smin); end
            4'b0110: begin res = (a - b) & mask; s = sa - sb; ovf = (s > smax) || (s < smin); end
            4'b0111: res = (sa < sb) ? 1 : 0;
            4'b0101: res = (a < b) ? 1 : 0;
            4'b1100: res = ~(a | b) & mask;
            4'b1101: res = a ^ b;
            4'b1000: begin p = a * b; res = p & mask; hi = (p >> w) & mask; lat = w + 1; end
            4'b1001: begin
                if (b == 0) begin res = mask; hi = a; dbz = 1; end
                else begin res = a / b; hi = a % b; lat = w + 1; end
            end
            default: res = 0;
        endcase
    endtask

    task automatic drive(input int w, input logic st, input logic [3:0] c,
                         input logic [31:0] a, input logic [31:0] b);
        if (w == 32) begin
            s32_start = st; s32_ctrl = c; s32_a = a; s32_b = b;
        end else begin
            s4_start = st; s4_ctrl = c; s4_a = a[3:0]; s4_b = b[3:0];
        end
    endtask

    task automatic sample(input int w, output logic [63:0] res, output logic [63:0] hi,
                          output logic zero, output logic ovf, output logic dbz,
                          output logic busy, output logic done);
        if (w == 32) begin
            res = 64'(o32_result); hi = 64'(o32_hi); zero = o32_zero; ovf = o32_ovf;
            dbz = o32_dbz; busy = o32_busy; done = o32_done;
        end else begin
            res = 64'(o4_result); hi = 64'(o4_hi); zero = o4_zero; ovf = o4_ovf;
            dbz = o4_dbz; busy = o4_busy; done = o4_done;
        end
    endtask

    task automatic run_op(input int w, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input string tag);
        logic [63:0] e_res, e_hi, res, hi;
        logic e_ovf, e_dbz, zero, ovf, dbz, busy, done;
        int e_lat, lat, busy_cnt;
        model(w, c, 64'(a), 64'(b), e_res, e_hi, e_ovf, e_dbz, e_lat);
        @(negedge clk);
        drive(w, 1'b1, c, a, b);
        @(posedge clk);
        #1;
        drive(w, 1'b0, 4'($urandom), $urandom, $urandom);
        lat = 1;
        busy_cnt = 0;
        sample(w, res, hi, zero, ovf, dbz, busy, done);
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            #1;
            lat++;
            sample(w, res, hi, zero, ovf, dbz, busy, done);
        end
        if (busy) busy_cnt++;
        check_eq({tag, "_lat"}, 64'(lat), 64'(e_lat));
        check_eq({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(e_lat));
        check_eq({tag, "_result"}, res, e_res);
        check_eq({tag, "_hi"}, hi, e_hi);
        check_eq({tag, "_zero"}, 64'(zero), 64'(e_res == 0));
        check_eq({tag, "_ovf"}, 64'(ovf), 64'(e_ovf));
        check_eq({tag, "_dbz"}, 64'(dbz), 64'(e_dbz));
        g_res = res;
        g_hi = hi;
        @(posedge clk);
        #1;
        sample(w, res, hi, zero, ovf, dbz, busy, done);
        check_eq({tag, "_done_1pulse"}, 64'(done), 64'd0);
        check_eq({tag, "_idle_after"}, 64'(busy), 64'd0);
    endtask

    logic [3:0] codes [11] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b0101,
                               4'b1100, 4'b1101, 4'b1000, 4'b1001, 4'b1111};

    initial begin
        int n_done;
        logic [31:0] ra, rb;
        logic [3:0] rc;
        rst = 1'b1;
        drive(32, 1'b0, 4'd0, 32'd0, 32'd0);
        drive(4, 1'b0, 4'd0, 32'd0, 32'd0);
        #12;
        rst = 1'b0;
        #1;
        check_eq("rst_result", 64'(o32_result), 64'd0);
        check_eq("rst_zero", 64'(o32_zero), 64'd1);
        check_eq("rst_busy", 64'(o32_busy), 64'd0);

        // Async reset, mid-cycle, with non-zero outputs held.
        run_op(32, 4'b0010, 32'h7FFF_FFFF, 32'h1, "add_ovf");
        check_eq("add_ovf_value", g_res, 64'h8000_0000);
        @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_eq("arst_result", 64'(o32_result), 64'd0);
        check_eq("arst_hi", 64'(o32_hi), 64'd0);
        check_eq("arst_zero", 64'(o32_zero), 64'd1);
        check_eq("arst_ovf", 64'(o32_ovf), 64'd0);
        check_eq("arst_busy", 64'(o32_busy), 64'd0);
        check_eq("arst_done", 64'(o32_done), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(32, 4'b0110, 32'd5, 32'd5, "sub_zero");
        run_op(32, 4'b0111, 32'hFFFF_FFFF, 32'd1, "slt");
        check_eq("slt_value", g_res, 64'd1);
        run_op(32, 4'b0101, 32'hFFFF_FFFF, 32'd1, "sltu");
        check_eq("sltu_value", g_res, 64'd0);
        run_op(32, 4'b1101, 32'hA5A5_0F0F, 32'h0F0F_A5A5, "xor");
        run_op(32, 4'b1100, 32'h1234_0000, 32'h0000_5678, "nor");
        run_op(32, 4'b1111, 32'hDEAD_BEEF, 32'h1, "undef");
        run_op(32, 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max");
        check_eq("mul_max_lo", g_res, 64'h1);
        check_eq("mul_max_hi", g_hi, 64'hFFFF_FFFE);
        run_op(32, 4'b1001, 32'd100, 32'd7, "div");
        check_eq("div_q", g_res, 64'd14);
        check_eq("div_r", g_hi, 64'd2);
        run_op(32, 4'b1001, 32'd5, 32'd0, "dbz");
        check_eq("dbz_q", g_res, 64'hFFFF_FFFF);
        run_op(32, 4'b0010, 32'd1, 32'd2, "dbz_clear");

        // start held high through a MUL: only the first request may complete.
        @(negedge clk);
        drive(32, 1'b1, 4'b1000, 32'd3, 32'd5);
        @(posedge clk);
        #1;
        drive(32, 1'b1, 4'b0010, $urandom, $urandom);
        n_done = 0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk);
            #1;
            if (o32_done) begin
                n_done++;
                g_res = 64'(o32_result);
            end
            s32_start = o32_busy && !o32_done;
            s32_a = $urandom;
        end
        check_eq("hs_done_count", 64'(n_done), 64'd1);
        check_eq("hs_result", g_res, 64'd15);

        for (int i = 0; i < 4; i++) begin
            run_op(32, 4'b0010, $urandom, $urandom, "b2b_add");
        end

        // Reset partway through a DIVU.
        @(negedge clk);
        drive(32, 1'b1, 4'b1001, 32'd1000, 32'd7);
        @(posedge clk);
        #1;
        drive(32, 1'b0, 4'd0, 32'd0, 32'd0);
        repeat (9) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_busy", 64'(o32_busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (o32_done) n_done++;
        end
        check_eq("mid_rst_no_done", 64'(n_done), 64'd0);
        run_op(32, 4'b0010, 32'd2, 32'd3, "post_rst_add");
        check_eq("post_rst_sum", g_res, 64'd5);

        run_op(4, 4'b1000, 32'hF, 32'hF, "w4_mul");
        check_eq("w4_mul_lo", g_res, 64'h1);
        check_eq("w4_mul_hi", g_hi, 64'hE);
        run_op(4, 4'b1001, 32'hF, 32'd4, "w4_div");
        check_eq("w4_div_q", g_res, 64'd3);
        check_eq("w4_div_r", g_hi, 64'd3);

        for (int i = 0; i < 40; i++) begin
            rc = codes[$urandom_range(0, 10)];
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            run_op(32, rc, ra, rb, "rand32");
        end
        for (int i = 0; i < 30; i++) begin
            rc = codes[$urandom_range(0, 10)];
            run_op(4, rc, $urandom_range(0, 15), $urandom_range(0, 15), "rand4");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
